// File: rtl/pio_access_arbiter.sv
// rtl/pio_access_arbiter.sv - two-requester arbiter for one Avalon-MM PIO slave (IDLE/ACCESS/ACK).
// Optional PIO_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise requester 0 wins.
module pio_access_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        r0_req,
   input  logic        r0_write,
   input  logic [1:0]  r0_address,
   input  logic [31:0] r0_writedata,
   output logic        r0_ack,
   output logic [31:0] r0_readdata,
   input  logic        r1_req,
   input  logic        r1_write,
   input  logic [1:0]  r1_address,
   input  logic [31:0] r1_writedata,
   output logic        r1_ack,
   output logic [31:0] r1_readdata,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [1:0]  pio_address,
   output logic [31:0] pio_writedata,
   input  logic [31:0] pio_readdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t state;
   logic   grant;      // 0 = requester 0, 1 = requester 1
   logic   lat_write;
   logic   grant_sel;

`ifdef PIO_ARB_ROUND_ROBIN_EN
   logic last_grant;

   always_comb begin
      grant_sel = 1'b0;
      if (r0_req && r1_req)
         grant_sel = ~last_grant;
      else
         grant_sel = r1_req;
   end
`else
   always_comb begin
      grant_sel = ~r0_req;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         grant          <= 1'b0;
         lat_write      <= 1'b0;
         pio_chipselect <= 1'b0;
         pio_write_n    <= 1'b1;
         pio_address    <= 2'd0;
         pio_writedata  <= 32'd0;
         r0_ack         <= 1'b0;
         r1_ack         <= 1'b0;
         r0_readdata    <= 32'd0;
         r1_readdata    <= 32'd0;
         busy           <= 1'b0;
`ifdef PIO_ARB_ROUND_ROBIN_EN
         last_grant     <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (r0_req || r1_req) begin
                  state          <= ACCESS;
                  grant          <= grant_sel;
                  lat_write      <= grant_sel ? r1_write : r0_write;
                  pio_address    <= grant_sel ? r1_address : r0_address;
                  pio_writedata  <= grant_sel ? r1_writedata : r0_writedata;
                  pio_write_n    <= grant_sel ? ~r1_write : ~r0_write;
                  pio_chipselect <= 1'b1;
                  busy           <= 1'b1;
`ifdef PIO_ARB_ROUND_ROBIN_EN
                  last_grant     <= grant_sel;
`endif
               end
            end
            ACCESS: begin
               // Slave read data is combinational, so capture it at the edge closing the access.
               state          <= ACK;
               pio_chipselect <= 1'b0;
               pio_write_n    <= 1'b1;
               r0_ack         <= ~grant;
               r1_ack         <= grant;
               if (!lat_write) begin
                  if (grant)
                     r1_readdata <= pio_readdata;
                  else
                     r0_readdata <= pio_readdata;
               end
            end
            ACK: begin
               state  <= IDLE;
               r0_ack <= 1'b0;
               r1_ack <= 1'b0;
               busy   <= 1'b0;
            end
            default: begin
               state          <= IDLE;
               pio_chipselect <= 1'b0;
               pio_write_n    <= 1'b1;
               r0_ack         <= 1'b0;
               r1_ack         <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// tb/tb_pio_access_arbiter.sv - randomized and directed bench for pio_access_arbiter with a transaction-level model.
// Honours PIO_ARB_ROUND_ROBIN_EN to pick the expected arbitration rule.
module tb_pio_access_arbiter;

   logic        clk;
   logic        reset_n;
   logic        r0_req, r0_write, r1_req, r1_write;
   logic [1:0]  r0_address, r1_address;
   logic [31:0] r0_writedata, r1_writedata;
   logic        r0_ack, r1_ack;
   logic [31:0] r0_readdata, r1_readdata;
   logic        pio_chipselect, pio_write_n, busy;
   logic [1:0]  pio_address;
   logic [31:0] pio_writedata, pio_readdata;

   logic [31:0] pio_regs [4];
   assign pio_readdata = pio_regs[pio_address];

   pio_access_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .r0_req(r0_req), .r0_write(r0_write), .r0_address(r0_address), .r0_writedata(r0_writedata),
      .r0_ack(r0_ack), .r0_readdata(r0_readdata),
      .r1_req(r1_req), .r1_write(r1_write), .r1_address(r1_address), .r1_writedata(r1_writedata),
      .r1_ack(r1_ack), .r1_readdata(r1_readdata),
      .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n), .pio_address(pio_address),
      .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: each grant at edge g is one access occupying cycles g (access) and g+1 (ack).
   int          cyc;
   int          free_edge;
   int          g_edge;
   int          g_who;
   logic        g_wr;
   logic [1:0]  g_addr;
   logic [31:0] g_data;
   int          m_last;
   logic [31:0] exp_mem [4];
   logic [31:0] exp_rd  [2];

   task automatic model_reset();
      free_edge = 0;
      g_edge    = -100;
      g_who     = 0;
      g_wr      = 1'b0;
      g_addr    = 2'd0;
      g_data    = 32'd0;
      m_last    = 1;
      for (int i = 0; i < 4; i++) exp_mem[i] = 32'd0;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
   endtask

   task automatic model_edge();
      int w;
      if (!reset_n) begin
         model_reset();
         return;
      end
      cyc++;
      if (cyc == g_edge + 1) begin
         if (g_wr) exp_mem[g_addr] = g_data;
         else      exp_rd[g_who]   = exp_mem[g_addr];
      end
      if (cyc >= free_edge && (r0_req || r1_req)) begin
         if (r0_req && r1_req) begin
`ifdef PIO_ARB_ROUND_ROBIN_EN
            w = (m_last == 0) ? 1 : 0;
`else
            w = 0;
`endif
         end else if (r0_req) w = 0;
         else                 w = 1;
         g_who     = w;
         g_wr      = (w == 0) ? r0_write : r1_write;
         g_addr    = (w == 0) ? r0_address : r1_address;
         g_data    = (w == 0) ? r0_writedata : r1_writedata;
         g_edge    = cyc;
         free_edge = cyc + 3;
         m_last    = w;
      end
   endtask

   task automatic check_outputs();
      logic in_acc, in_ack;
      in_acc = (cyc == g_edge);
      in_ack = (cyc == g_edge + 1);
      check_eq("busy", busy, in_acc || in_ack);
      check_eq("chipselect", pio_chipselect, in_acc);
      check_eq("write_n", pio_write_n, in_acc ? !g_wr : 1'b1);
      check_eq("pio_address", pio_address, g_addr);
      check_eq("pio_writedata", pio_writedata, g_data);
      check_eq("r0_ack", r0_ack, in_ack && g_who == 0);
      check_eq("r1_ack", r1_ack, in_ack && g_who == 1);
      check_eq("r0_readdata", r0_readdata, exp_rd[0]);
      check_eq("r1_readdata", r1_readdata, exp_rd[1]);
   endtask

   // Advance one clock: slave write, model update at the edge, then check at the falling edge.
   task automatic tick();
      @(posedge clk);
      if (reset_n && pio_chipselect && !pio_write_n) pio_regs[pio_address] = pio_writedata;
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drive(input int who, input logic req, input logic wr, input logic [1:0] a,
                        input logic [31:0] d);
      if (who == 0) begin
         r0_req = req; r0_write = wr; r0_address = a; r0_writedata = d;
      end else begin
         r1_req = req; r1_write = wr; r1_address = a; r1_writedata = d;
      end
   endtask

   function automatic logic ack_of(input int who);
      return (who == 0) ? r0_ack : r1_ack;
   endfunction

   task automatic wait_ack(input int who);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack_of(who)) begin
            ok = 1'b1;
            break;
         end
      end
      if (who == 0) r0_req = 1'b0;
      else          r1_req = 1'b0;
      check_eq("ack_seen", ok, 1'b1);
   endtask

   task automatic do_access(input int who, input logic wr, input logic [1:0] a, input logic [31:0] d);
      drive(who, 1'b1, wr, a, d);
      wait_ack(who);
   endtask

   task automatic apply_reset(input int n);
      reset_n = 1'b0;
      drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
      for (int i = 0; i < 4; i++) pio_regs[i] = 32'd0;
      model_reset();
      #1;
      check_outputs();
      repeat (n) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          seq[$];
      int          pend[2];
      logic [31:0] got;
      cyc = 0;
      model_reset();
      reset_n = 1'b1;
      drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
      for (int i = 0; i < 4; i++) pio_regs[i] = 32'd0;
      @(negedge clk);
      apply_reset(2);
      repeat (2) tick();

      // r0 writes 2 to address 0, then r1 reads it back
      do_access(0, 1'b1, 2'd0, 32'h2);
      check_eq("pio_out_port", pio_regs[0], 32'h2);
      tick();
      do_access(1, 1'b0, 2'd0, 32'h0);
      check_eq("r1_read_back", r1_readdata, 32'h2);
      check_eq("r0_rd_untouched", r0_readdata, 32'h0);
      tick();

      // writedata changed during ACCESS must be ignored
      drive(0, 1'b1, 1'b1, 2'd1, 32'h1);
      tick();
      check_eq("in_access", pio_chipselect, 1'b1);
      r0_writedata = 32'h3;
      wait_ack(0);
      check_eq("latched_wdata", pio_regs[1], 32'h1);
      tick();

      // both requesters held high together
      drive(0, 1'b1, 1'b1, 2'd2, 32'hA5A5_0001);
      drive(1, 1'b1, 1'b0, 2'd2, 32'h0);
      repeat (12) begin
         tick();
         if (r0_ack) seq.push_back(0);
         if (r1_ack) seq.push_back(1);
      end
      check_eq("contend_acks", seq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         got = (i < seq.size()) ? seq[i] : 99;
`ifdef PIO_ARB_ROUND_ROBIN_EN
         check_eq("contend_order", got, i % 2);
`else
         check_eq("contend_order", got, 0);
`endif
      end
      r0_req = 1'b0;
      wait_ack(1);
      tick();

      // reset in the middle of an ACCESS cycle
      drive(0, 1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF);
      tick();
      check_eq("pre_reset_cs", pio_chipselect, 1'b1);
      apply_reset(2);
      repeat (5) tick();
      do_access(1, 1'b0, 2'd0, 32'h0);
      check_eq("post_reset_read", r1_readdata, 32'h0);
      tick();

      // randomized traffic from both requesters
      pend[0] = 0;
      pend[1] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int w = 0; w < 2; w++) begin
            if (pend[w] != 0) begin
               if (ack_of(w)) begin
                  if (w == 0) r0_req = 1'b0; else r1_req = 1'b0;
                  pend[w] = 0;
               end else if ($urandom_range(3) == 0) begin
                  if (w == 0) r0_writedata = $urandom; else r1_writedata = $urandom;
               end
            end else if ($urandom_range(2) == 0) begin
               drive(w, 1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)), $urandom);
               pend[w] = 1;
            end
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pio_access_arbiter.md
PIO_ACCESS_ARBITER -- requirements
Module: pio_access_arbiter

Interface
REQ-001 SHALL have clock clk and reset reset_n, asynchronous, active-low.
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset_n in 1 async active-low reset.
REQ-003 r0_req in 1 requester 0 access request, held high until r0_ack; r0_write in 1 1=write, 0=read; r0_address in 2 PIO register address; r0_writedata in 32 write data.
REQ-004 r0_ack out 1 one-cycle completion pulse; r0_readdata out 32 captured read data.
REQ-005 r1_req, r1_write, r1_address, r1_writedata, r1_ack, r1_readdata: identical to requester 0 ports, for requester 1.
REQ-006 pio_chipselect out 1; pio_write_n out 1 (active-low); pio_address out 2; pio_writedata out 32; pio_readdata in 32 (combinational from slave): Avalon-MM master side to the PIO slave.
REQ-007 busy out 1 high whenever the FSM is not IDLE.

Function
REQ-008 FSM states: IDLE, ACCESS, ACK; transitions IDLE->ACCESS on grant, ACCESS->ACK unconditionally, ACK->IDLE unconditionally.
REQ-009 In IDLE, if any rX_req is high at a rising edge, SHALL select a grant, latch that requester's write/address/writedata and enter ACCESS.
REQ-010 In ACCESS (exactly one cycle), pio_chipselect=1, pio_address/pio_writedata = latched values, pio_write_n = ~latched write; otherwise pio_chipselect=0, pio_write_n=1.
REQ-011 At the edge ending ACCESS, a read SHALL capture pio_readdata into the granted requester's rX_readdata; a write SHALL leave rX_readdata unchanged.
REQ-012 In ACK, only the granted requester's rX_ack SHALL be 1 for exactly one cycle.
REQ-013 Latency: req sampled at edge N -> chipselect during cycle N+1 -> ack during cycle N+2; max throughput one access per 3 cycles.
REQ-014 Requester SHALL drop req in the cycle after ack; a req still high in IDLE is treated as a new request.
REQ-015 Changes on rX_req/rX_* inputs during ACCESS or ACK SHALL be ignored (values latched).
REQ-016 Non-granted requester's req SHALL remain pending and be served at the next IDLE; no request lost.
REQ-017 rX_readdata SHALL hold its value until the next read completion for that requester.
REQ-018 pio_address/pio_writedata SHALL hold latched values outside ACCESS (no glitch requirement beyond chipselect=0).

Reset
REQ-019 Asynchronous reset SHALL force: state IDLE, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, r0_ack=r1_ack=0, r0_readdata=r1_readdata=0, busy=0, last_grant=1.
REQ-020 Reset asserted during ACCESS SHALL drop pio_chipselect immediately; the aborted access SHALL NOT produce an ack after reset release.

Configuration
REQ-021 Macro PIO_ARB_ROUND_ROBIN_EN defined: when both request in IDLE, grant the requester not granted last; last_grant updated at every grant; reset value makes requester 0 win first.
REQ-022 PIO_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins simultaneous requests; last_grant register absent.
REQ-023 Single-requester behaviour SHALL be identical in both configurations.

Verification
REQ-024 r0 write addr=0 data=0x00000002 -> chipselect=1, write_n=0 in cycle N+1; r0_ack in N+2; PIO out_port=2'b10.
REQ-025 After REQ-024, r1 read addr=0 -> r1_readdata=0x00000002 with r1_ack in N+2; r0_readdata unchanged (0).
REQ-026 r0 and r1 both request in the same cycle, held continuously (RR build) -> grants r0,r1,r0,r1; acks every 3 cycles; fixed-priority build -> r1 served only after r0 drops req.
REQ-027 r0 changes writedata from 0x1 to 0x3 during ACCESS -> PIO receives 0x1.
REQ-028 reset_n low in ACCESS cycle -> chipselect=0 same cycle, no ack after release, busy=0, next r1 read returns 0.
